// File: rtl/operand_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_pkg
// Description : Shared definitions for the operand-fetch stage. Holds the
//               instruction field layout, opcode constants, the stage FSM
//               state type and the hard-wired-zero register address.
// Revision    : 1.0 - initial release
// ============================================================================
package operand_fetch_pkg;

  // Instruction field layout for the 16-bit instruction word
  localparam int OPC_LSB   = 12;
  localparam int OPC_W     = 4;
  localparam int RD_LSB    = 9;
  localparam int RS1_LSB   = 6;
  localparam int RS2_LSB   = 3;
  localparam int FUNCT_LSB = 0;
  localparam int FUNCT_W   = 3;
  localparam int IMM_LSB   = 0;
  localparam int IMM_W     = 6;

  // Opcode constants shared with decode/execute
  localparam logic [OPC_W-1:0] OPC_ALU   = 4'h0;
  localparam logic [OPC_W-1:0] OPC_ADDI  = 4'h1;
  localparam logic [OPC_W-1:0] OPC_LOAD  = 4'h2;
  localparam logic [OPC_W-1:0] OPC_STORE = 4'h3;
  localparam logic [OPC_W-1:0] OPC_BEQ   = 4'h4;
  localparam logic [OPC_W-1:0] OPC_JMP   = 4'h5;

  // Register r0 always reads as zero and is never a forwarding target
  localparam int R0_ADDR = 0;

  // Stage FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/operand_bypass.sv
`default_nettype none
// ============================================================================
// Module      : operand_bypass
// Description : Combinational operand select for one register-file read
//               port: r0 -> zero, else matching writeback -> wb data, else
//               register-file read data. Also reports the forwarding hit so
//               the parent can snoop writebacks while holding a bundle.
// Ports       : ra_i       read address of this port
//               rf_rd_i    register file read data for ra_i
//               wb_we_i / wb_wa_i / wb_wd_i  writeback snoop
//               hit_o      writeback targets ra_i (never for r0)
//               operand_o  selected operand
// Revision    : 1.0 - initial release
// ============================================================================
module operand_bypass
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int AREG_W = 3,
  parameter int BYPASS = 1
) (
  input  logic [AREG_W-1:0] ra_i,
  input  logic [DATA_W-1:0] rf_rd_i,
  input  logic              wb_we_i,
  input  logic [AREG_W-1:0] wb_wa_i,
  input  logic [DATA_W-1:0] wb_wd_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] operand_o
);

  logic w_fwd_en;
  logic w_is_r0;

  generate
    if (BYPASS != 0) begin : g_fwd_on
      assign w_fwd_en = 1'b1;
    end else begin : g_fwd_off
      assign w_fwd_en = 1'b0;
    end
  endgenerate

  assign w_is_r0 = (ra_i == AREG_W'(R0_ADDR));

  always_comb begin
    hit_o     = w_fwd_en && wb_we_i && (wb_wa_i == ra_i) && !w_is_r0;
    operand_o = rf_rd_i;
    if (w_is_r0) begin
      operand_o = '0;
    end else if (hit_o) begin
      operand_o = wb_wd_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch
// Description : Operand-fetch stage. Latches one instruction word per
//               handshake, reads both source registers (with writeback
//               bypass) into A/B, and presents the decoded bundle to execute
//               under a valid/ready handshake. One instruction per 2 cycles.
// Ports       : clk, reset               clock, synchronous active-high reset
//               in_valid/in_ready, instr, pc_in   upstream handshake + word
//               ra1/ra2, rd1/rd2          register file read port
//               wb_we/wb_wa/wb_wd         register file write-port snoop
//               out_valid/out_ready       downstream handshake
//               out_a/out_b/out_imm/out_opcode/out_rd/out_funct/out_pc
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int AREG_W = 3,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   instr,
  input  logic [DATA_W-1:0]   pc_in,
  output logic [AREG_W-1:0]   ra1,
  output logic [AREG_W-1:0]   ra2,
  input  logic [DATA_W-1:0]   rd1,
  input  logic [DATA_W-1:0]   rd2,
  input  logic                wb_we,
  input  logic [AREG_W-1:0]   wb_wa,
  input  logic [DATA_W-1:0]   wb_wd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_a,
  output logic [DATA_W-1:0]   out_b,
  output logic [DATA_W-1:0]   out_imm,
  output logic [OPC_W-1:0]    out_opcode,
  output logic [AREG_W-1:0]   out_rd,
  output logic [FUNCT_W-1:0]  out_funct,
  output logic [DATA_W-1:0]   out_pc
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;

  logic                w_accept;
  logic                w_hit1, w_hit2;
  logic [DATA_W-1:0]   w_op1, w_op2;

  assign w_accept = in_valid && in_ready;

  // Read addresses always follow the latched IR
  assign ra1 = ir_q[RS1_LSB +: AREG_W];
  assign ra2 = ir_q[RS2_LSB +: AREG_W];

  operand_bypass #(
    .DATA_W (DATA_W),
    .AREG_W (AREG_W),
    .BYPASS (BYPASS)
  ) u_bypass_a (
    .ra_i      (ra1),
    .rf_rd_i   (rd1),
    .wb_we_i   (wb_we),
    .wb_wa_i   (wb_wa),
    .wb_wd_i   (wb_wd),
    .hit_o     (w_hit1),
    .operand_o (w_op1)
  );

  operand_bypass #(
    .DATA_W (DATA_W),
    .AREG_W (AREG_W),
    .BYPASS (BYPASS)
  ) u_bypass_b (
    .ra_i      (ra2),
    .rf_rd_i   (rd2),
    .wb_we_i   (wb_we),
    .wb_wa_i   (wb_wa),
    .wb_wd_i   (wb_wd),
    .hit_o     (w_hit2),
    .operand_o (w_op2)
  );

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (w_accept) state_d = ST_READ;
      ST_READ: state_d = ST_HOLD;
      ST_HOLD: if (out_ready) state_d = in_valid ? ST_READ : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
    out_valid = (state_q == ST_HOLD);
  end

  // Datapath next values. In HOLD only a forwarding hit may touch A/B; the
  // IR can be reloaded in HOLD on a simultaneous hand-off and accept.
  always_comb begin
    ir_d = w_accept ? instr : ir_q;
    pc_d = w_accept ? pc_in : pc_q;
    a_d  = a_q;
    b_d  = b_q;
    if (state_q == ST_READ) begin
      a_d = w_op1;
      b_d = w_op2;
    end else if (state_q == ST_HOLD) begin
      if (w_hit1) a_d = wb_wd;
      if (w_hit2) b_d = wb_wd;
    end
  end

  assign out_a      = a_q;
  assign out_b      = b_q;
  assign out_pc     = pc_q;
  assign out_opcode = ir_q[OPC_LSB +: OPC_W];
  assign out_rd     = ir_q[RD_LSB +: AREG_W];
  assign out_funct  = ir_q[FUNCT_LSB +: FUNCT_W];
  assign out_imm    = {{(DATA_W-IMM_W){ir_q[IMM_LSB+IMM_W-1]}}, ir_q[IMM_LSB +: IMM_W]};

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_fetch
// Description : Self-checking bench for operand_fetch. A behavioural register
//               file drives the read ports; accepted words are decoded into a
//               scoreboard queue and a negedge monitor checks every hand-off.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic [15:0] pc_in;
  logic [2:0]  ra1, ra2, ra1_nb, ra2_nb;
  logic [15:0] rd1, rd2, rd1_nb, rd2_nb;
  logic        wb_we;
  logic [2:0]  wb_wa;
  logic [15:0] wb_wd;
  logic        out_valid, out_ready;
  logic [15:0] out_a, out_b, out_imm, out_pc;
  logic [3:0]  out_opcode;
  logic [2:0]  out_rd, out_funct;
  // Outputs of the non-forwarding instance
  logic        in_ready_nb, out_valid_nb;
  logic [15:0] out_a_nb, out_b_nb, out_imm_nb, out_pc_nb;
  logic [3:0]  out_opcode_nb;
  logic [2:0]  out_rd_nb, out_funct_nb;

  always #5 clk = ~clk;

  // Behavioural register file: r0 reads zero, writes land on the edge
  logic [15:0] rf [8];
  initial for (int i = 0; i < 8; i++) rf[i] = 16'h0;
  always @(posedge clk) if (wb_we && wb_wa != 3'd0) rf[wb_wa] <= wb_wd;

  function automatic logic [15:0] rf_read(input logic [2:0] a);
    return (a == 3'd0) ? 16'h0 : rf[a];
  endfunction

  assign rd1    = rf_read(ra1);
  assign rd2    = rf_read(ra2);
  assign rd1_nb = rf_read(ra1_nb);
  assign rd2_nb = rf_read(ra2_nb);

  operand_fetch #(.DATA_W(16), .AREG_W(3), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc_in(pc_in), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_imm(out_imm), .out_opcode(out_opcode), .out_rd(out_rd),
    .out_funct(out_funct), .out_pc(out_pc)
  );

  operand_fetch #(.DATA_W(16), .AREG_W(3), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_nb),
    .instr(instr), .pc_in(pc_in), .ra1(ra1_nb), .ra2(ra2_nb), .rd1(rd1_nb),
    .rd2(rd2_nb), .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .out_valid(out_valid_nb), .out_ready(out_ready), .out_a(out_a_nb),
    .out_b(out_b_nb), .out_imm(out_imm_nb), .out_opcode(out_opcode_nb),
    .out_rd(out_rd_nb), .out_funct(out_funct_nb), .out_pc(out_pc_nb)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected bundle, decoded from the instruction word by field arithmetic
  typedef struct {
    logic [15:0] pc;
    logic [3:0]  opc;
    logic [2:0]  rd, rs1, rs2, funct;
    logic [15:0] imm;
  } item_t;

  function automatic item_t decode(input logic [15:0] w, input logic [15:0] pc);
    item_t it;
    logic [15:0] v;
    it.pc    = pc;
    it.opc   = 4'(w >> 12);
    it.rd    = 3'((w >> 9) % 8);
    it.rs1   = 3'((w >> 6) % 8);
    it.rs2   = 3'((w >> 3) % 8);
    it.funct = 3'(w % 8);
    v = w % 64;
    if (v >= 16'd32) v = v - 16'd64;
    it.imm = v;
    return it;
  endfunction

  item_t exp_q[$];

  // Monitor: pop and compare on every hand-off, push on every accept, and
  // check that the held bundle fields stay put while stalled.
  initial begin
    item_t it;
    logic        prev_hold = 1'b0;
    logic [15:0] h_pc, h_imm;
    logic [3:0]  h_opc;
    logic [2:0]  h_rd, h_funct;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_pc", 32'(out_pc), 32'(h_pc));
          chk("hold_opcode", 32'(out_opcode), 32'(h_opc));
          chk("hold_rd", 32'(out_rd), 32'(h_rd));
          chk("hold_funct", 32'(out_funct), 32'(h_funct));
          chk("hold_imm", 32'(out_imm), 32'(h_imm));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got out_valid=1 expected no pending word (t=%0t)", $time);
          end else begin
            it = exp_q.pop_front();
            chk("sb_pc", 32'(out_pc), 32'(it.pc));
            chk("sb_opcode", 32'(out_opcode), 32'(it.opc));
            chk("sb_rd", 32'(out_rd), 32'(it.rd));
            chk("sb_funct", 32'(out_funct), 32'(it.funct));
            chk("sb_imm", 32'(out_imm), 32'(it.imm));
            chk("sb_a", 32'(out_a), 32'(rf_read(it.rs1)));
            chk("sb_b", 32'(out_b), 32'(rf_read(it.rs2)));
          end
        end
        if (in_valid && in_ready) exp_q.push_back(decode(instr, pc_in));
        prev_hold = out_valid && !out_ready;
        h_pc = out_pc; h_imm = out_imm; h_opc = out_opcode;
        h_rd = out_rd; h_funct = out_funct;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
    wb_we = 1'b1; wb_wa = a; wb_wd = d;
    tick();
    wb_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; instr = 16'h0; pc_in = 16'h0;
    wb_we = 1'b0; wb_wa = 3'd0; wb_wd = 16'h0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_a", 32'(out_a), 32'd0);
    chk("rst_ra1", 32'(ra1), 32'd0);
    chk("rst_out_pc", 32'(out_pc), 32'd0);
    chk("rst_out_imm", 32'(out_imm), 32'd0);

    write_reg(3'd2, 16'h1234);
    write_reg(3'd3, 16'h00FF);

    // Basic fetch
    out_ready = 1'b1; instr = 16'h1298; pc_in = 16'h0100; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("read_in_ready", 32'(in_ready), 32'd0);
    chk("read_out_valid", 32'(out_valid), 32'd0);
    chk("read_ra1", 32'(ra1), 32'd2);
    chk("read_ra2", 32'(ra2), 32'd3);
    tick();
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_a", 32'(out_a), 32'h1234);
    chk("basic_b", 32'(out_b), 32'h00FF);
    chk("basic_rd", 32'(out_rd), 32'd1);
    chk("basic_imm", 32'(out_imm), 32'h0018);
    chk("basic_opcode", 32'(out_opcode), 32'd1);
    chk("basic_pc", 32'(out_pc), 32'h0100);
    tick();
    chk("basic_done_valid", 32'(out_valid), 32'd0);

    // Same-cycle bypass into A
    pc_in = 16'h0104; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wb_we = 1'b1; wb_wa = 3'd2; wb_wd = 16'hBEEF;
    tick();
    wb_we = 1'b0;
    chk("byp_a", 32'(out_a), 32'hBEEF);
    tick();

    // Same-cycle write to rs2: forwarded vs stale without forwarding
    pc_in = 16'h0108; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wb_we = 1'b1; wb_wa = 3'd3; wb_wd = 16'h5555;
    tick();
    wb_we = 1'b0;
    chk("byp_b", 32'(out_b), 32'h5555);
    chk("nobyp_b_stale", 32'(out_b_nb), 32'h00FF);
    tick();

    // r0 write is never forwarded
    instr = 16'h280D; pc_in = 16'h010C; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wb_we = 1'b1; wb_wa = 3'd0; wb_wd = 16'hFFFF;
    tick();
    wb_we = 1'b0;
    chk("r0_a", 32'(out_a), 32'd0);
    chk("r0_rd", 32'(out_rd), 32'd4);
    tick();

    // Backpressure, ignored input, and hold-state snoop into B
    out_ready = 1'b0; instr = 16'h280D; pc_in = 16'h0110; in_valid = 1'b1;
    tick();
    instr = 16'h1298; pc_in = 16'hDEAD;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_pc", 32'(out_pc), 32'h0110);
      tick();
    end
    write_reg(3'd1, 16'h0042);
    chk("snoop_b", 32'(out_b), 32'h0042);
    chk("snoop_a", 32'(out_a), 32'd0);
    chk("snoop_pc", 32'(out_pc), 32'h0110);
    chk("snoop_valid", 32'(out_valid), 32'd1);
    chk("snoop_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp_done_valid", 32'(out_valid), 32'd0);

    // Back-to-back with out_ready high
    for (int k = 0; k < 8; k++) begin
      instr = 16'h3000 | 16'(k * 73);
      pc_in = 16'h0300 + 16'(k);
      in_valid = 1'b1;
      tick();
      chk("b2b_valid", 32'(out_valid), 32'(k % 2));
      if (k % 2 == 1) chk("b2b_pc", 32'(out_pc), 32'h0300 + 32'(k - 1));
    end

    // Reset while in READ drops the in-flight word
    tick();
    chk("pre_rst_valid", 32'(out_valid), 32'd0);
    reset = 1'b1; in_valid = 1'b0;
    tick();
    reset = 1'b0;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_pc", 32'(out_pc), 32'd0);
    chk("midrst_a", 32'(out_a), 32'd0);

    // Randomized traffic with writebacks, stalls and occasional resets
    for (int k = 0; k < 800; k++) begin
      reset     = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      instr     = 16'($urandom);
      pc_in     = 16'($urandom);
      wb_we     = $urandom_range(0, 1) == 1;
      wb_wa     = 3'($urandom_range(0, 7));
      wb_wd     = 16'($urandom);
      tick();
    end

    // Drain
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; wb_we = 1'b0;
    repeat (4) tick();
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
